// File: rtl/peripheral_bb_wb_master.sv
// Wishbone B4 burst master: accepts a request of 1..16 beats, streams write data
// or returns read data per beat, and aborts on slave error or per-beat timeout.
module peripheral_bb_wb_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [AW-1:0]   req_adr_i,
    input  logic            req_we_i,
    input  logic [DW/8-1:0] req_sel_i,
    input  logic [3:0]      req_len_i,

    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    input  logic [DW-1:0]   wr_dat_i,

    output logic            rsp_valid_o,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            rsp_last_o,

    output logic            busy_o,

    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i
);

    localparam int SW = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDATA  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic            we_q, we_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      beat_q, beat_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_last_q, rsp_last_d;

    logic final_beat;
    logic timed_out;

    assign final_beat = (beat_q == len_q);
    assign timed_out  = (tmo_q == TMO_LAST);

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        len_d       = len_q;
        beat_d      = beat_q;
        wdat_d      = wdat_q;
        tmo_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = '0;
        rsp_err_d   = 1'b0;
        rsp_last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    adr_d   = req_adr_i;
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    len_d   = req_len_i;
                    beat_d  = '0;
                    state_d = req_we_i ? WDATA : ACTIVE;
                end
            end
            WDATA: begin
                if (wr_valid_i) begin
                    wdat_d  = wr_dat_i;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // Error beats ack, and a silent slave is treated as an error.
                if (wb_err_i || (timed_out && !wb_ack_i)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_dat_d   = (wb_err_i && !we_q) ? wb_dat_i : '0;
                    state_d     = IDLE;
                end else if (wb_ack_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = final_beat;
                    rsp_dat_d   = we_q ? '0 : wb_dat_i;
                    adr_d       = adr_q + AW'(SW);
                    if (final_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        state_d = we_q ? WDATA : ACTIVE;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            wdat_q      <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wdat_q      <= wdat_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // The cycle stays open between write beats while the next word is awaited.
    assign wb_stb_o = (state_q == ACTIVE);
    assign wb_cyc_o = wb_stb_o || ((state_q == WDATA) && (beat_q != 4'd0));
    assign wb_we_o  = wb_cyc_o && we_q;
    assign wb_sel_o = wb_cyc_o ? sel_q : '0;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = wdat_q;
    assign wb_bte_o = 2'b00;
    assign wb_cti_o = (!wb_stb_o || (len_q == 4'd0)) ? CTI_CLASSIC
                    : (final_beat ? CTI_END : CTI_INCR);

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign wr_ready_o  = (state_q == WDATA);
    assign busy_o      = (state_q != IDLE);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_peripheral_bb_wb_master.sv
// Bench for peripheral_bb_wb_master: a transaction-level model predicts bus beats and
// responses; a per-cycle monitor compares the DUT against it, plus literal spot checks.
module tb_peripheral_bb_wb_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_adr_i;
  logic [3:0]  req_sel_i, req_len_i;
  logic        wr_valid_i, wr_ready_o;
  logic [31:0] wr_dat_i;
  logic        rsp_valid_o, rsp_err_o, rsp_last_o, busy_o;
  logic [31:0] rsp_dat_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;

  always #5 clk = ~clk;

  peripheral_bb_wb_master #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_adr_i(req_adr_i),
    .req_we_i(req_we_i), .req_sel_i(req_sel_i), .req_len_i(req_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_dat_i(wr_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .rsp_last_o(rsp_last_o), .busy_o(busy_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // kind: 0 ack, 1 err, 2 err+ack together, 3 slave silent (timeout)
  typedef struct { int lat; int kind; logic [31:0] rdat; } plan_t;
  typedef struct { logic [31:0] adr; logic [2:0] cti; logic [3:0] sel; logic we; logic [31:0] wdat; logic ends; } beat_t;
  typedef struct { logic [31:0] dat; logic err; logic last; } rsp_t;
  typedef struct { logic [31:0] dat; logic err; logic last; int cyc; } rlog_t;
  typedef struct { logic [31:0] adr; logic [2:0] cti; logic [31:0] wdat; int cyc; } blog_t;

  plan_t       plan_q[$];
  beat_t       exp_beats[$];
  rsp_t        exp_rsps[$];
  logic [31:0] wq[$];
  rlog_t       rlog[$];
  blog_t       blog[$];

  int          t_lat[16];
  int          t_kind[16];
  logic [31:0] t_rd[16];
  logic [31:0] t_wd[16];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit exp_busy = 1'b0;
  bit exp_rsp = 1'b0;
  int scnt_s = 0;
  int scnt_c = 0;
  int cyc_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Transaction-level model: beat i runs at start+4*i until the first aborting beat.
  task automatic build_model(input logic [31:0] adr, input logic we, input logic [3:0] sel, input int len);
    beat_t b;
    rsp_t  r;
    plan_t p;
    bit    abort;
    for (int i = 0; i <= len; i++) begin
      abort  = (t_kind[i] != 0);
      b.adr  = adr + 32'(4 * i);
      b.cti  = (len == 0) ? 3'b000 : ((i == len) ? 3'b111 : 3'b010);
      b.sel  = sel;
      b.we   = we;
      b.wdat = t_wd[i];
      b.ends = abort || (i == len);
      r.dat  = (we || t_kind[i] == 3) ? 32'h0 : t_rd[i];
      r.err  = abort;
      r.last = b.ends;
      p.lat  = t_lat[i];
      p.kind = t_kind[i];
      p.rdat = t_rd[i];
      exp_beats.push_back(b);
      exp_rsps.push_back(r);
      plan_q.push_back(p);
      if (we) wq.push_back(t_wd[i]);
      if (abort) break;
    end
  endtask

  task automatic start_tx(input logic [31:0] adr, input logic we, input logic [3:0] sel, input int len);
    build_model(adr, we, sel, len);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    req_valid_i = 1'b1;
    req_adr_i   = adr;
    req_we_i    = we;
    req_sel_i   = sel;
    req_len_i   = 4'(len);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy_o || exp_rsps.size() != 0) && n < 400) begin
      req_valid_i = busy_o ? 1'($urandom_range(0, 1)) : 1'b0;
      req_adr_i   = $urandom;
      req_we_i    = 1'($urandom_range(0, 1));
      req_len_i   = 4'($urandom_range(0, 15));
      @(negedge clk);
      n++;
    end
    req_valid_i = 1'b0;
    check("tx_completes_in_budget", 64'(busy_o), 64'd0);
    check("all_beats_seen", 64'(exp_beats.size()), 64'd0);
    exp_beats.delete();
    exp_rsps.delete();
    plan_q.delete();
    wq.delete();
  endtask

  task automatic run_tx(input logic [31:0] adr, input logic we, input logic [3:0] sel, input int len);
    rlog.delete();
    blog.delete();
    start_tx(adr, we, sel, len);
    wait_done();
  endtask

  task automatic rand_tx();
    logic [31:0] adr;
    int          len;
    int          k;
    adr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                      : ($urandom & 32'hFFFF_FFFC);
    len = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
    for (int i = 0; i < 16; i++) begin
      k         = $urandom_range(0, 99);
      t_lat[i]  = $urandom_range(0, 3);
      t_kind[i] = (k < 85) ? 0 : (k < 90) ? 1 : (k < 95) ? 2 : 3;
      t_rd[i]   = $urandom;
      t_wd[i]   = $urandom;
    end
    run_tx(adr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), len);
  endtask

  // Slave + write-data feeder on the falling edge, then the compare process 2 ns later.
  always @(negedge clk) begin
    plan_t p;
    beat_t b;
    rsp_t  r;
    bit    nb;
    bit    nr;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = $urandom;
    if (wb_stb_o && plan_q.size() != 0) begin
      p = plan_q[0];
      if (p.kind == 3) begin
        if (scnt_s == TMO - 1) begin
          void'(plan_q.pop_front());
          scnt_s = 0;
        end else scnt_s++;
      end else if (scnt_s == p.lat) begin
        wb_ack_i = (p.kind != 1);
        wb_err_i = (p.kind != 0);
        wb_dat_i = p.rdat;
        void'(plan_q.pop_front());
        scnt_s = 0;
      end else scnt_s++;
    end else if (!wb_stb_o) begin
      scnt_s   = 0;
      wb_ack_i = ($urandom_range(0, 3) == 0);
      wb_err_i = ($urandom_range(0, 7) == 0);
    end
    wr_valid_i = 1'b0;
    wr_dat_i   = $urandom;
    if (wr_ready_o) begin
      if (wq.size() != 0 && $urandom_range(0, 2) != 0) begin
        wr_valid_i = 1'b1;
        wr_dat_i   = wq.pop_front();
      end
    end else wr_valid_i = 1'($urandom_range(0, 1));

    #2;
    cyc_n++;
    if (rsp_valid_o) rlog.push_back('{rsp_dat_o, rsp_err_o, rsp_last_o, cyc_n});
    if (wb_stb_o && scnt_c == 0) blog.push_back('{wb_adr_o, wb_cti_o, wb_dat_o, cyc_n});
    if (!chk_en) begin
      exp_busy = 1'b0;
      exp_rsp  = 1'b0;
      scnt_c   = 0;
    end else begin
      nb = exp_busy;
      nr = 1'b0;
      check("busy", 64'(busy_o), 64'(exp_busy));
      check("req_ready", 64'(req_ready_o), 64'(!exp_busy));
      check("bte", 64'(wb_bte_o), 64'd0);
      check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp));
      if (rsp_valid_o) begin
        if (exp_rsps.size() == 0) check("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
        else begin
          r = exp_rsps.pop_front();
          check("rsp_dat", 64'(rsp_dat_o), 64'(r.dat));
          check("rsp_err", 64'(rsp_err_o), 64'(r.err));
          check("rsp_last", 64'(rsp_last_o), 64'(r.last));
        end
      end
      if (!exp_busy) check("cyc_stb_when_idle", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
      if (wb_stb_o) begin
        if (exp_beats.size() == 0) check("stb_unexpected", 64'(wb_stb_o), 64'd0);
        else begin
          b = exp_beats[0];
          check("wb_cyc_with_stb", 64'(wb_cyc_o), 64'd1);
          check("wb_adr", 64'(wb_adr_o), 64'(b.adr));
          check("wb_cti", 64'(wb_cti_o), 64'(b.cti));
          check("wb_sel", 64'(wb_sel_o), 64'(b.sel));
          check("wb_we", 64'(wb_we_o), 64'(b.we));
          if (b.we) check("wb_dat_o", 64'(wb_dat_o), 64'(b.wdat));
          if (wb_ack_i || wb_err_i || scnt_c == TMO - 1) begin
            void'(exp_beats.pop_front());
            nr = 1'b1;
            if (b.ends) nb = 1'b0;
            scnt_c = 0;
          end else scnt_c++;
        end
      end else scnt_c = 0;
      if (req_valid_i && req_ready_o) nb = 1'b1;
      exp_busy = nb;
      exp_rsp  = nr;
    end
  end

  initial begin
    logic [31:0] adr_lit [4];
    logic [2:0]  cti_lit [4];
    int          n;
    bit          rsp_in_reset;
    adr_lit = '{32'h200, 32'h204, 32'h208, 32'h20C};
    cti_lit = '{3'b010, 3'b010, 3'b010, 3'b111};
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_adr_i = '0; req_we_i = 1'b0; req_sel_i = '0; req_len_i = '0;
    wr_valid_i = 1'b0; wr_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_wb_ctrl", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o}), 64'd0);
    check("rst_wb_adr", 64'(wb_adr_o), 64'd0);
    check("rst_wb_dat", 64'(wb_dat_o), 64'd0);
    check("rst_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_last_o}), 64'd0);
    check("rst_rsp_dat", 64'(rsp_dat_o), 64'd0);
    check("rst_handshakes", 64'({busy_o, req_ready_o, wr_ready_o}), 64'd0);
    @(negedge clk);
    rst_i  = 1'b0;
    chk_en = 1'b1;
    #1 check("ready_first_cycle_after_reset", 64'(req_ready_o), 64'd1);

    // single read, ack on the second strobe cycle
    t_lat[0] = 1; t_kind[0] = 0; t_rd[0] = 32'hDEAD_BEEF;
    run_tx(32'h100, 1'b0, 4'hF, 0);
    check("single_rsp_count", 64'(rlog.size()), 64'd1);
    check("single_beat_count", 64'(blog.size()), 64'd1);
    if (rlog.size() >= 1 && blog.size() >= 1) begin
      check("single_rsp_dat", 64'(rlog[0].dat), 64'hDEAD_BEEF);
      check("single_rsp_flags", 64'({rlog[0].err, rlog[0].last}), 64'b01);
      check("single_cti", 64'(blog[0].cti), 64'd0);
      check("single_rsp_latency", 64'(rlog[0].cyc - blog[0].cyc), 64'd2);
    end

    // 4-beat write, immediate acks
    for (int i = 0; i < 4; i++) begin
      t_lat[i] = 0; t_kind[i] = 0; t_wd[i] = 32'hA + 32'(i); t_rd[i] = $urandom;
    end
    run_tx(32'h200, 1'b1, 4'hF, 3);
    check("wr4_beat_count", 64'(blog.size()), 64'd4);
    check("wr4_rsp_count", 64'(rlog.size()), 64'd4);
    if (blog.size() >= 4 && rlog.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("wr4_adr", 64'(blog[i].adr), 64'(adr_lit[i]));
        check("wr4_cti", 64'(blog[i].cti), 64'(cti_lit[i]));
        check("wr4_dat", 64'(blog[i].wdat), 64'hA + 64'(i));
        check("wr4_last", 64'(rlog[i].last), 64'(i == 3));
      end
    end

    // 16-beat read across the top of the address space
    for (int i = 0; i < 16; i++) begin
      t_lat[i] = $urandom_range(0, 2); t_kind[i] = 0; t_rd[i] = $urandom;
    end
    run_tx(32'hFFFF_FFF8, 1'b0, 4'h3, 15);
    check("wrap_beat_count", 64'(blog.size()), 64'd16);
    check("wrap_rsp_count", 64'(rlog.size()), 64'd16);
    if (blog.size() >= 16) begin
      check("wrap_adr_beat2", 64'(blog[1].adr), 64'hFFFF_FFFC);
      check("wrap_adr_beat3", 64'(blog[2].adr), 64'h0);
      check("wrap_adr_beat16", 64'(blog[15].adr), 64'h34);
    end

    // err together with ack on the first of two beats
    t_lat[0] = 0; t_kind[0] = 2; t_rd[0] = 32'h1234_5678;
    t_lat[1] = 0; t_kind[1] = 0;
    run_tx(32'h300, 1'b0, 4'hF, 1);
    check("err_rsp_count", 64'(rlog.size()), 64'd1);
    check("err_beat_count", 64'(blog.size()), 64'd1);
    if (rlog.size() >= 1) check("err_rsp_flags", 64'({rlog[0].err, rlog[0].last}), 64'b11);

    // silent slave
    t_kind[0] = 3; t_rd[0] = 32'hFFFF_FFFF;
    run_tx(32'h400, 1'b0, 4'hF, 0);
    check("tmo_rsp_count", 64'(rlog.size()), 64'd1);
    if (rlog.size() >= 1 && blog.size() >= 1) begin
      check("tmo_rsp_dat", 64'(rlog[0].dat), 64'd0);
      check("tmo_rsp_flags", 64'({rlog[0].err, rlog[0].last}), 64'b11);
      check("tmo_latency", 64'(rlog[0].cyc - blog[0].cyc), 64'(TMO));
    end

    for (int t = 0; t < 60; t++) rand_tx();

    // reset in the middle of an 8-beat read
    for (int i = 0; i < 8; i++) begin
      t_lat[i] = 0; t_kind[i] = 0; t_rd[i] = $urandom;
    end
    rlog.delete();
    blog.delete();
    start_tx(32'h800, 1'b0, 4'hF, 7);
    n = 0;
    while (rlog.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_reached_beat3", 64'(rlog.size() >= 3), 64'd1);
    chk_en = 1'b0;
    rst_i  = 1'b1;
    @(negedge clk);
    #1;
    check("mid_reset_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    check("mid_reset_rsp", 64'(rsp_valid_o), 64'd0);
    check("mid_reset_outputs", 64'({wb_adr_o, wb_cti_o, busy_o, req_ready_o}), 64'd0);
    n = rlog.size();
    exp_beats.delete(); exp_rsps.delete(); plan_q.delete(); wq.delete();
    @(negedge clk);
    rst_i = 1'b0;
    #1 check("ready_after_mid_reset", 64'(req_ready_o), 64'd1);
    rsp_in_reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 if (rsp_valid_o || wb_cyc_o) rsp_in_reset = 1'b1;
    end
    check("no_rsp_after_reset", 64'(rsp_in_reset), 64'd0);
    check("rsp_log_frozen", 64'(rlog.size()), 64'(n));
    chk_en = 1'b1;

    for (int t = 0; t < 5; t++) rand_tx();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/peripheral_bb_wb_master.md
PERIPHERAL_BB_WB_MASTER -- requirements
Module: peripheral_bb_wb_master

Interface
REQ-001 Parameter AW, default 32, address bus width.
REQ-002 Parameter DW, default 32, data bus width; DW/8 byte selects.
REQ-003 Parameter TIMEOUT, default 255, max cycles a beat waits for ack/err.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 req_valid_i  in  1  transaction request valid.
REQ-007 req_ready_o  out  1  request accepted when valid and ready both high.
REQ-008 req_adr_i  in  AW  start byte address.
REQ-009 req_we_i  in  1  1 = write, 0 = read.
REQ-010 req_sel_i  in  DW/8  byte selects, used for every beat.
REQ-011 req_len_i  in  4  beat count minus 1 (0 = single, 15 = 16 beats).
REQ-012 wr_valid_i / wr_ready_o / wr_dat_i  in / out / DW  write-data stream, one word per beat.
REQ-013 rsp_valid_o / rsp_dat_o / rsp_err_o / rsp_last_o  out / out DW / out / out  per-beat response; no backpressure.
REQ-014 busy_o  out  1  transaction in progress.
REQ-015 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  WishBone cycle, strobe, write enable.
REQ-016 wb_adr_o  out  AW;  wb_dat_o  out  DW;  wb_sel_o  out  DW/8.
REQ-017 wb_cti_o  out  3;  wb_bte_o  out  2, constant 2'b00 (linear).
REQ-018 wb_dat_i  in  DW;  wb_ack_i  in  1;  wb_err_i  in  1.

Function
REQ-019 States SHALL be IDLE, WDATA, ACTIVE.
REQ-020 req_ready_o SHALL be high only in IDLE and not in reset; acceptance latches address, we, sel, len; beat counter cleared.
REQ-021 IDLE->WDATA on accepted write; IDLE->ACTIVE on accepted read.
REQ-022 WDATA: wr_ready_o=1; on wr_valid_i, latch wr_dat_i into wb_dat_o, go ACTIVE next cycle; wb_cyc_o stays high in WDATA after first beat, wb_stb_o low.
REQ-023 ACTIVE: wb_cyc_o=wb_stb_o=1, wb_we_o = latched we, wb_sel_o = latched sel.
REQ-024 wb_cti_o: 3'b000 when len=0; 3'b010 on non-final burst beats; 3'b111 on final burst beat.
REQ-025 On wb_ack_i in ACTIVE: beat completes; wb_adr_o += DW/8 modulo 2^AW (wraps 0xFFFFFFFC -> 0x00000000).
REQ-026 After non-final ack: read stays ACTIVE (next beat strobed next cycle); write -> WDATA.
REQ-027 After final ack: -> IDLE; wb_cyc_o/wb_stb_o low next cycle.
REQ-028 Response SHALL be registered: rsp_valid_o pulses one cycle, the cycle after ack/err/timeout is sampled.
REQ-029 rsp_dat_o = sampled wb_dat_i for reads, 0 for writes; rsp_last_o=1 on final or aborting beat.
REQ-030 wb_err_i in ACTIVE: response with rsp_err_o=1, rsp_last_o=1; remaining beats abandoned; -> IDLE.
REQ-031 wb_ack_i and wb_err_i same cycle: err wins.
REQ-032 Timeout counter restarts at each beat's first ACTIVE cycle; TIMEOUT cycles without ack/err -> same as err with rsp_dat_o=0.
REQ-033 wb_ack_i/wb_err_i outside ACTIVE SHALL be ignored.
REQ-034 busy_o = (state != IDLE).

Reset
REQ-035 rst_i high at a clock edge: state IDLE, all outputs 0 (including wb_cti_o, wb_adr_o, rsp_*), counters cleared.
REQ-036 Reset mid-transaction: wb_cyc_o/wb_stb_o low at next edge, no response emitted for the aborted beat.
REQ-037 req_ready_o high from the first cycle with rst_i low.

Verification
REQ-038 Single read, adr 0x100, len 0; slave acks 2nd strobe cycle with 0xDEADBEEF -> cti 000, one rsp 0xDEADBEEF, last=1, err=0, cyc low after.
REQ-039 4-beat write from 0x200, wr data A..D, immediate ack -> adr 0x200/204/208/20C, cti 010,010,010,111, wb_dat_o matches, 4 rsp, last on 4th.
REQ-040 16-beat read from 0xFFFFFFF8 -> addresses wrap to 0x00000000 on beat 3; 16 rsp pulses.
REQ-041 2-beat read, err on beat 1 with ack same cycle -> one rsp err=1 last=1, no beat 2, IDLE.
REQ-042 TIMEOUT=8, slave never acks -> rsp err=1, dat=0 exactly 8 cycles into beat; cyc low.
REQ-043 rst_i asserted mid 8-beat read after beat 3 -> cyc/stb low next edge, no further rsp, req_ready_o high after release.
